// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the parameterised register file.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clrState_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_ZERO_REG   = 1;
  localparam int DEF_BYPASS     = 1;

endpackage

// File: rtl/regfile_if.sv
// Register-file access bundle: one write port, two read ports, scoreboard and clear control.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

  logic                  ctrl_writeEn;
  logic [ADDR_WIDTH-1:0] ctrl_writeReg;
  logic [DATA_WIDTH-1:0] data_writeReg;
  logic [ADDR_WIDTH-1:0] ctrl_readRegA;
  logic [ADDR_WIDTH-1:0] ctrl_readRegB;
  logic [DATA_WIDTH-1:0] data_readRegA;
  logic [DATA_WIDTH-1:0] data_readRegB;
  logic                  ctrl_setPending;
  logic [ADDR_WIDTH-1:0] ctrl_pendingReg;
  logic                  pending_A;
  logic                  pending_B;
  logic                  ctrl_clear;
  logic                  clear_busy;

  modport master (
    output ctrl_writeEn, ctrl_writeReg, data_writeReg,
    output ctrl_readRegA, ctrl_readRegB,
    output ctrl_setPending, ctrl_pendingReg, ctrl_clear,
    input  data_readRegA, data_readRegB, pending_A, pending_B, clear_busy
  );

  modport slave (
    input  ctrl_writeEn, ctrl_writeReg, data_writeReg,
    input  ctrl_readRegA, ctrl_readRegB,
    input  ctrl_setPending, ctrl_pendingReg, ctrl_clear,
    output data_readRegA, data_readRegB, pending_A, pending_B, clear_busy
  );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Soft-clear sequencer: walks a sweep index over every clearable register, one per cycle.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = DEF_ZERO_REG
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  ctrl_clear,
  output logic                  zeroEn,
  output logic                  sweepStart,
  output logic                  clearBusy,
  output logic [ADDR_WIDTH-1:0] sweepIdx
);

  // A hardwired register 0 never needs zeroing, so the sweep skips it.
  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = (ZERO_REG != 0) ? ADDR_WIDTH'(1) : '0;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = '1;

  clrState_e             state_r;
  logic [ADDR_WIDTH-1:0] idx_r;

  // Clear FSM: IDLE waits for a request, SWEEP advances the index until the top register.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state_r <= IDLE;
      idx_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (ctrl_clear) begin
            state_r <= SWEEP;
            idx_r   <= FIRST_IDX;
          end else begin
            state_r <= IDLE;
            idx_r   <= idx_r;
          end
        end
        SWEEP: begin
          if (idx_r == LAST_IDX) begin
            state_r <= IDLE;
            idx_r   <= '0;
          end else begin
            state_r <= SWEEP;
            idx_r   <= idx_r + ADDR_WIDTH'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          idx_r   <= '0;
        end
      endcase
    end
  end

  assign zeroEn     = (state_r == SWEEP);
  assign clearBusy  = (state_r == SWEEP);
  assign sweepStart = (state_r == IDLE) && ctrl_clear;
  assign sweepIdx   = idx_r;

endmodule

// File: rtl/regfile_param.sv
// Parameterised two-read/one-write register file with pending scoreboard and soft-clear sweep.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = DEF_ZERO_REG,
  parameter int BYPASS     = DEF_BYPASS
) (
  input  logic      clock,
  input  logic      ctrl_reset,
  regfile_if.slave  bus
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
  logic [NUM_REGS-1:0]   pending_r;
  logic                  zeroEn_s;
  logic                  sweepStart_s;
  logic                  clearBusy_s;
  logic [ADDR_WIDTH-1:0] sweepIdx_s;
  logic                  writeAcc_s;
  logic [NUM_REGS-1:0]   setMask_s;
  logic [NUM_REGS-1:0]   clrMask_s;
  logic [DATA_WIDTH-1:0] readA_s;
  logic [DATA_WIDTH-1:0] readB_s;

  function automatic logic isZeroReg(input logic [ADDR_WIDTH-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  regfile_clear_fsm #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG  (ZERO_REG)
  ) u_clearFsm (
    .clock     (clock),
    .ctrl_reset(ctrl_reset),
    .ctrl_clear(bus.ctrl_clear),
    .zeroEn    (zeroEn_s),
    .sweepStart(sweepStart_s),
    .clearBusy (clearBusy_s),
    .sweepIdx  (sweepIdx_s)
  );

  // Writes to a hardwired zero register are treated as never accepted, so they neither store nor forward.
  assign writeAcc_s = bus.ctrl_writeEn && !clearBusy_s && !isZeroReg(bus.ctrl_writeReg);

  // Storage update: reset, sweep zeroing, or an accepted write.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (zeroEn_s) begin
      regs_r[sweepIdx_s] <= '0;
    end else if (writeAcc_s) begin
      regs_r[bus.ctrl_writeReg] <= bus.data_writeReg;
    end
  end

  // Scoreboard set/clear masks for this cycle.
  always_comb begin
    setMask_s = '0;
    clrMask_s = '0;
    if (bus.ctrl_setPending && !isZeroReg(bus.ctrl_pendingReg)) begin
      setMask_s[bus.ctrl_pendingReg] = 1'b1;
    end else begin
      setMask_s = '0;
    end
    if (writeAcc_s) begin
      clrMask_s[bus.ctrl_writeReg] = 1'b1;
    end else begin
      clrMask_s = '0;
    end
  end

  // Scoreboard update: a set overrides a same-cycle write clear; a sweep start wipes everything.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      pending_r <= '0;
    end else if (sweepStart_s) begin
      pending_r <= '0;
    end else begin
      pending_r <= (pending_r & ~clrMask_s) | setMask_s;
    end
  end

  // Read ports: zero register, then same-cycle forwarding, then storage.
  always_comb begin
    readA_s = regs_r[bus.ctrl_readRegA];
    readB_s = regs_r[bus.ctrl_readRegB];
    if (isZeroReg(bus.ctrl_readRegA)) begin
      readA_s = '0;
    end else if ((BYPASS != 0) && writeAcc_s && (bus.ctrl_readRegA == bus.ctrl_writeReg)) begin
      readA_s = bus.data_writeReg;
    end else begin
      readA_s = regs_r[bus.ctrl_readRegA];
    end
    if (isZeroReg(bus.ctrl_readRegB)) begin
      readB_s = '0;
    end else if ((BYPASS != 0) && writeAcc_s && (bus.ctrl_readRegB == bus.ctrl_writeReg)) begin
      readB_s = bus.data_writeReg;
    end else begin
      readB_s = regs_r[bus.ctrl_readRegB];
    end
  end

  assign bus.data_readRegA = readA_s;
  assign bus.data_readRegB = readB_s;
  assign bus.pending_A     = pending_r[bus.ctrl_readRegA];
  assign bus.pending_B     = pending_r[bus.ctrl_readRegB];
  assign bus.clear_busy    = clearBusy_s;

endmodule
